// File: rtl/key_input_conditioner.sv
// key_input_conditioner: synchronise, debounce and edge-detect active-low push-buttons.
// Optional build macro KEY_EXCLUSIVE_EN forwards only one key at a time.  Rev 1.0
`default_nettype none

module key_input_conditioner #(
  parameter int NUM_KEYS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n_raw,
  output logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                any_key
);

  localparam int               CNT_W  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] w_sync;
  logic [NUM_KEYS-1:0] w_db_next;
  logic [NUM_KEYS-1:0] r_db;
  logic [NUM_KEYS-1:0] w_rise;
  logic [NUM_KEYS-1:0] w_fall;

  genvar i;
  generate
    for (i = 0; i < NUM_KEYS; i++) begin : g_key
      logic [SYNC_STAGES-1:0] r_sync;
      logic [CNT_W-1:0]       r_cnt;

      // Chain resets to "released" so a held button looks like a fresh press.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_sync <= '1;
        else        r_sync <= {r_sync[SYNC_STAGES-2:0], key_n_raw[i]};
      end

      assign w_sync[i]    = ~r_sync[SYNC_STAGES-1];
      assign w_db_next[i] = ((w_sync[i] != r_db[i]) && (r_cnt == C_LAST)) ? w_sync[i] : r_db[i];

      always_ff @(posedge clock or negedge reset) begin
        if (!reset)                                     r_cnt <= '0;
        else if ((w_sync[i] == r_db[i]) || (r_cnt == C_LAST)) r_cnt <= '0;
        else                                            r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  endgenerate

  assign w_rise = w_db_next & ~r_db;
  assign w_fall = r_db & ~w_db_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_db <= '0;
    else        r_db <= w_db_next;
  end

`ifdef KEY_EXCLUSIVE_EN
  logic [NUM_KEYS-1:0] r_grant;
  logic [NUM_KEYS-1:0] w_grant_next;

  // Grant only on a fresh rise, so keys held while masked never inherit it.
  always_comb begin
    w_grant_next = r_grant;
    if (r_grant == '0)
      w_grant_next = w_rise & (~w_rise + NUM_KEYS'(1));
    else if ((w_fall & r_grant) != '0)
      w_grant_next = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_grant     <= '0;
      key         <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      r_grant     <= w_grant_next;
      key         <= w_db_next & w_grant_next;
      key_press   <= w_rise & w_grant_next;
      key_release <= w_fall & r_grant;
    end
  end
`else
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key         <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      key         <= w_db_next;
      key_press   <= w_rise;
      key_release <= w_fall;
    end
  end
`endif

  assign any_key = |key;

endmodule

`default_nettype wire

// File: doc/key_input_conditioner.md
Name: key_input_conditioner

Overview:
- Front-end for the digital lock. Takes the raw active-low DE1-SoC push-buttons and produces the clean active-high `key` vector that the lock FSM consumes.
- Synchronises, debounces and edge-detects each button.
- Guarantees one press/release event per physical actuation, with no bounce glitches reaching the FSM.
- Sits between the board pins and the lock FSM's `key` input, in the top level.

Parameters:
- NUM_KEYS, 4, number of buttons conditioned (matches the lock FSM `key` width).
- SYNC_STAGES, 2, flip-flops in each input synchroniser chain (legal range 2..4).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before accepting a level change (minimum 2).

Ports:
- clock  input  1  system clock.
- reset  input  1  one clock; reset is asynchronous and active-low.
- key_n_raw  input  NUM_KEYS  raw button pins, active-low (0 = pressed), asynchronous to clock.
- key  output  NUM_KEYS  debounced level, active-high (1 = held); drives the lock FSM `key`.
- key_press  output  NUM_KEYS  one-cycle pulse per key on its accepted press.
- key_release  output  NUM_KEYS  one-cycle pulse per key on its accepted release.
- any_key  output  1  OR of `key`.

Behaviour:
- Reset (reset=0, asynchronous):
  - All synchroniser flops set to 1 (released).
  - Debounce counters cleared to 0.
  - key, key_press, key_release and any_key all 0.
- Synchroniser: per-bit chain of SYNC_STAGES flops. Its output is inverted to an active-high `sync[i]`.
- Debounce, per key i, with counter width clog2(DEBOUNCE_CYCLES)+1:
  - If sync[i] == key[i] at a clock edge, counter[i] is cleared to 0.
  - If sync[i] != key[i] and counter[i] < DEBOUNCE_CYCLES-1, counter[i] increments.
  - If sync[i] != key[i] and counter[i] == DEBOUNCE_CYCLES-1, then key[i] <= sync[i] and counter[i] is cleared.
  - Counter never wraps; it saturates via the compare above.
- Latency:
  - A raw level held stable from sampling edge 1 onward appears on key[i] after edge SYNC_STAGES+DEBOUNCE_CYCLES.
  - With the defaults this is exactly 50002 edges.
  - Release latency is identical.
- Glitch rejection: any disagreement lasting fewer than DEBOUNCE_CYCLES synchronised cycles produces no change on key, key_press or key_release.
- Edge pulses:
  - key_press[i] is high for exactly the one cycle in which key[i] first reads 1. It is registered and updated on the same edge as key[i].
  - key_release[i] behaves the same way on key[i] falling.
  - Pulses for different keys are independent and may coincide.
- any_key is combinational from the registered `key`.
- Button held through reset deassertion: treated as a fresh press. key[i] rises and key_press[i] pulses SYNC_STAGES+DEBOUNCE_CYCLES edges after reset release.
- Reset asserted mid-debounce: the count is discarded and no pulse is emitted.
- Simultaneous press of several keys (no option compiled): each key is conditioned independently.

Optional Feature:
- Macro: KEY_EXCLUSIVE_EN.
- Defined:
  - Only one key is forwarded at a time.
  - When key outputs are all 0, the first key to complete debounce is granted. On a same-edge tie, the lowest index wins.
  - Other keys are masked to 0 on key, key_press and key_release until the granted key's release pulse.
  - A masked key still held after the grant ends is not forwarded until it is released and pressed again.
  - The internal debounced state is still tracked for all keys.
- Undefined: no masking; all keys are forwarded independently as described above.

Test Plan (bench parameters: SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
- Reset then idle with key_n_raw=4'hF -> key=0, no pulses for 20 cycles, any_key=0.
- key_n_raw=4'hE held stable from edge 1 -> key=4'h1 and key_press=4'h1 for one cycle after edge 6. Setting 4'hF afterwards -> key=0 and key_release=4'h1 six edges later.
- Bounce on key0: low for 3 cycles, high for 1, low for 3, then high -> key stays 0, no pulses. Then low for 10 cycles -> exactly one key_press[0].
- Assert reset during edge 4 of a key2 press -> outputs 0 immediately. With key2 still held, release reset -> key[2] rises six edges later with one key_press pulse.
- Raw 4'hC (keys 0 and 1) applied on the same edge:
  - Without KEY_EXCLUSIVE_EN: key=4'h3 and key_press=4'h3.
  - With KEY_EXCLUSIVE_EN: key=4'h1 only. key1 is not forwarded until it is released and pressed again.
- Pressing 4 keys in sequence with release gaps -> key_press pulses in order 1,2,4,8 with exactly four pulses total, and no overlap on `key`.
